// File: rtl/gppcu_instr_dispatcher_if.sv
// Instruction-dispatch bus: host control, instruction RAM read port and core
// instruction port, bundled so the dispatcher and its environment share one definition.
interface gppcu_instr_dispatcher_if #(
    parameter int DBW  = 32,
    parameter int IABW = 10
) ();
    logic            iSTART;
    logic            iABORT;
    logic [IABW-1:0] iPROG_BASE;
    logic [IABW:0]   iPROG_LEN;
    logic            oBUSY;
    logic            oDONE;
    logic [IABW-1:0] oIMEM_ADDR;
    logic            oIMEM_RD;
    logic [DBW-1:0]  iIMEM_RDATA;
    logic [DBW-1:0]  oINSTR;
    logic            oINSTR_VALID;
    logic            iINSTR_READY;
    logic [IABW:0]   oISSUED_CNT;

    // Dispatcher side.
    modport master (
        input  iSTART, iABORT, iPROG_BASE, iPROG_LEN, iIMEM_RDATA, iINSTR_READY,
        output oBUSY, oDONE, oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID, oISSUED_CNT
    );

    // Host, instruction RAM and core side.
    modport slave (
        output iSTART, iABORT, iPROG_BASE, iPROG_LEN, iIMEM_RDATA, iINSTR_READY,
        input  oBUSY, oDONE, oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID, oISSUED_CNT
    );
endinterface

// File: rtl/gppcu_instr_dispatcher.sv
// Streams a program from a synchronous instruction RAM into the GPPCU core through a
// 2-entry skid buffer, honours core backpressure, then waits for the core pipeline to
// drain before pulsing done. DRAIN_CYCLES must be at least 2.
module gppcu_instr_dispatcher #(
    parameter int DBW          = 32,
    parameter int IABW         = 10,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                    iACLK,
    input  logic                    iRST,
    gppcu_instr_dispatcher_if.master bus
);
    localparam int            DCW     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IABW:0] LEN_ONE = (IABW + 1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} stateT;

    stateT           state, stateNext;
    logic [IABW-1:0] rdAddr;
    logic [IABW:0]   progLen, readsIssued, issuedCnt;
    logic            rdPending;
    logic [DBW-1:0]  fifoMem [2];
    logic            wrPtr, rdPtr;
    logic [1:0]      fifoCount;
    logic [DCW-1:0]  drainCnt;
    logic            doneReg;

    logic            instrValid, xfer, lastXfer, abortFlush;
    logic [2:0]      occAfter;
    logic            rdEn, latchStart, enterDrain, finishDrain;

    assign instrValid = (fifoCount != 2'd0);
    assign xfer       = instrValid && bus.iINSTR_READY;
    assign lastXfer   = xfer && ((issuedCnt + LEN_ONE) == progLen);
    assign abortFlush = bus.iABORT && (state != IDLE);
    // Slots still committed once this cycle's transfer leaves; a read may go out while
    // fewer than two are committed, which sustains one instruction per cycle.
    assign occAfter   = 3'(fifoCount) + 3'(rdPending) - 3'(xfer);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        stateNext   = state;
        rdEn        = 1'b0;
        latchStart  = 1'b0;
        enterDrain  = 1'b0;
        finishDrain = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.iSTART && !bus.iABORT) begin
                    latchStart = 1'b1;
                    if (bus.iPROG_LEN == '0) begin
                        stateNext  = DRAIN;
                        enterDrain = 1'b1;
                    end else begin
                        stateNext  = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.iABORT) begin
                    stateNext = IDLE;
                end else begin
                    rdEn = (readsIssued < progLen) && (occAfter < 3'd2);
                    if (lastXfer) begin
                        stateNext  = DRAIN;
                        enterDrain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.iABORT) begin
                    stateNext = IDLE;
                end else if (drainCnt <= DCW'(1)) begin
                    stateNext   = IDLE;
                    finishDrain = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Program bookkeeping: read address, counters, drain timer and done pulse.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            rdAddr      <= '0;
            progLen     <= '0;
            readsIssued <= '0;
            issuedCnt   <= '0;
            rdPending   <= 1'b0;
            drainCnt    <= '0;
            doneReg     <= 1'b0;
        end else begin
            rdPending <= rdEn;
            doneReg   <= finishDrain;
            if (latchStart) begin
                rdAddr      <= bus.iPROG_BASE;
                progLen     <= bus.iPROG_LEN;
                readsIssued <= '0;
                issuedCnt   <= '0;
            end else begin
                if (rdEn) begin
                    rdAddr      <= rdAddr + IABW'(1);
                    readsIssued <= readsIssued + LEN_ONE;
                end
                if (xfer) issuedCnt <= issuedCnt + LEN_ONE;
            end
            if (enterDrain)
                drainCnt <= DCW'(DRAIN_CYCLES - 1);
            else if ((state == DRAIN) && (drainCnt != '0))
                drainCnt <= drainCnt - DCW'(1);
        end
    end

    // Skid-buffer pointers and occupancy; abort flushes, discarding any read return.
    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            fifoCount <= 2'd0;
        end else if (abortFlush) begin
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            fifoCount <= 2'd0;
        end else begin
            if (rdPending) wrPtr <= ~wrPtr;
            if (xfer)      rdPtr <= ~rdPtr;
            fifoCount <= fifoCount + 2'(rdPending) - 2'(xfer);
        end
    end

    // Skid-buffer storage captures read data the cycle it returns.
    // NOTE: storage has no reset; the output mux below hides stale entries while empty.
    always_ff @(posedge iACLK) begin
        if (rdPending && !abortFlush) fifoMem[wrPtr] <= bus.iIMEM_RDATA;
    end

    assign bus.oBUSY        = (state != IDLE);
    assign bus.oDONE        = doneReg;
    assign bus.oIMEM_ADDR   = rdAddr;
    assign bus.oIMEM_RD     = rdEn;
    assign bus.oINSTR       = instrValid ? fifoMem[rdPtr] : '0;
    assign bus.oINSTR_VALID = instrValid;
    assign bus.oISSUED_CNT  = issuedCnt;
endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Bench for gppcu_instr_dispatcher: table of directed programs, hand-written abort and
// reset sequences, and random programs with random core backpressure, all checked
// against a program-level model (expected stream = RAM[base+i mod 1024]).
module tb_gppcu_instr_dispatcher;
    localparam int DBW   = 32;
    localparam int IABW  = 10;
    localparam int DEPTH = 1 << IABW;

    logic iACLK, iRST;

    gppcu_instr_dispatcher_if #(.DBW(DBW), .IABW(IABW)) bus ();

    gppcu_instr_dispatcher #(.DBW(DBW), .IABW(IABW), .DRAIN_CYCLES(4)) dut (
        .iACLK (iACLK),
        .iRST  (iRST),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic [9:0]    base;
        logic [10:0]   len;
        int            mode;        // 0 ready high, 1 alternating, 2 random
        bit            midStart;    // pulse a stray start while busy
        int            expDoneOff;  // done cycle relative to start, -1 = model only
        int            expIssued;
    } vecT;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          readyMode = 0;
    int          stopAfter = 0;
    logic [31:0] ram [DEPTH];

    logic [31:0] gotQ[$];
    int          xferCycQ[$];
    int          rdAddrQ[$];
    int          rdCycQ[$];
    int          doneCycQ[$];
    int          stallErr = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevInstr = '0;

    initial iACLK = 1'b0;
    always #5 iACLK = ~iACLK;

    always @(posedge iACLK) cyc <= cyc + 1;

    // Synchronous instruction RAM; junk on the data bus when not read.
    always @(posedge iACLK) begin
        if (bus.oIMEM_RD) bus.iIMEM_RDATA <= ram[bus.oIMEM_ADDR];
        else              bus.iIMEM_RDATA <= 32'hDEAD_0000 ^ 32'(cyc);
    end

    // Core backpressure.
    always @(posedge iACLK) begin
        #1;
        case (readyMode)
            0:       bus.iINSTR_READY = 1'b1;
            1:       bus.iINSTR_READY = ((cyc % 2) == 0);
            2:       bus.iINSTR_READY = ($urandom_range(0, 3) != 0);
            3:       bus.iINSTR_READY = (gotQ.size() < stopAfter);
            default: bus.iINSTR_READY = 1'b0;
        endcase
    end

    // Observe the DUT mid-cycle: reads, transfers, done pulses, stall stability.
    always @(negedge iACLK) begin
        if (iRST) begin
            prevStall = 1'b0;
        end else begin
            if (bus.oIMEM_RD) begin
                rdAddrQ.push_back(int'(bus.oIMEM_ADDR));
                rdCycQ.push_back(cyc);
            end
            if (bus.oINSTR_VALID && bus.iINSTR_READY) begin
                gotQ.push_back(bus.oINSTR);
                xferCycQ.push_back(cyc);
            end
            if (bus.oDONE) doneCycQ.push_back(cyc);
            if (prevStall && (!bus.oINSTR_VALID || bus.oINSTR !== prevInstr)) stallErr++;
            prevStall = bus.oINSTR_VALID && !bus.iINSTR_READY && !bus.iABORT;
            prevInstr = bus.oINSTR;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_obs();
        gotQ.delete(); xferCycQ.delete(); rdAddrQ.delete(); rdCycQ.delete();
        doneCycQ.delete(); stallErr = 0;
    endtask

    task automatic start_prog(input logic [9:0] base, input logic [10:0] len, output int startCyc);
        @(posedge iACLK); #1;
        bus.iSTART = 1'b1; bus.iPROG_BASE = base; bus.iPROG_LEN = len;
        startCyc = cyc;
        @(posedge iACLK); #1;
        bus.iSTART = 1'b0; bus.iPROG_BASE = ~base; bus.iPROG_LEN = len + 11'd3;
    endtask

    // Run one program to completion and compare against the program-level model.
    task automatic do_run(input string tag, input logic [9:0] base, input logic [10:0] len,
                          input int mode, input bit midStart, input int expDoneOff,
                          input int expIssued);
        int startCyc, budget, k, lastRef, n;
        clear_obs();
        readyMode = mode;
        start_prog(base, len, startCyc);
        budget = (int'(len) + 8) * 16;
        k = 0;
        while (doneCycQ.size() == 0 && k < budget) begin
            @(posedge iACLK); #1;
            bus.iSTART = midStart && (k == 0);
            bus.iPROG_BASE = 10'h000; bus.iPROG_LEN = 11'd1;
            k++;
        end
        bus.iSTART = 1'b0;
        repeat (3) @(posedge iACLK);
        #1;
        n = int'(len);
        check({tag, " done count"}, 64'(doneCycQ.size()), 64'd1);
        check({tag, " xfer count"}, 64'(gotQ.size()), 64'(n));
        for (int i = 0; i < n && i < gotQ.size(); i++)
            check($sformatf("%s instr[%0d]", tag, i), 64'(gotQ[i]), 64'(ram[(int'(base) + i) % DEPTH]));
        check({tag, " read count"}, 64'(rdAddrQ.size()), 64'(n));
        for (int i = 0; i < n && i < rdAddrQ.size(); i++)
            check($sformatf("%s rd addr[%0d]", tag, i), 64'(rdAddrQ[i]), 64'((int'(base) + i) % DEPTH));
        lastRef = (n == 0 || xferCycQ.size() == 0) ? startCyc : xferCycQ[$];
        if (doneCycQ.size() > 0) begin
            check({tag, " done cycle"}, 64'(doneCycQ[0] - lastRef), 64'd4);
            if (expDoneOff >= 0)
                check({tag, " done offset"}, 64'(doneCycQ[0] - startCyc), 64'(expDoneOff));
        end
        if (mode == 0 && n > 0 && rdCycQ.size() > 0 && xferCycQ.size() > 0) begin
            check({tag, " first rd latency"}, 64'(rdCycQ[0] - startCyc), 64'd1);
            check({tag, " first valid latency"}, 64'(xferCycQ[0] - startCyc), 64'd3);
            check({tag, " throughput"}, 64'(xferCycQ[$] - xferCycQ[0]), 64'(n - 1));
        end
        check({tag, " issued cnt"}, 64'(bus.oISSUED_CNT), 64'(expIssued));
        check({tag, " busy after"}, 64'(bus.oBUSY), 64'd0);
        check({tag, " valid after"}, 64'(bus.oINSTR_VALID), 64'd0);
        check({tag, " stall stability"}, 64'(stallErr), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(bus.oBUSY), 64'd0);
        check({tag, " done"}, 64'(bus.oDONE), 64'd0);
        check({tag, " rd"}, 64'(bus.oIMEM_RD), 64'd0);
        check({tag, " addr"}, 64'(bus.oIMEM_ADDR), 64'd0);
        check({tag, " instr"}, 64'(bus.oINSTR), 64'd0);
        check({tag, " valid"}, 64'(bus.oINSTR_VALID), 64'd0);
        check({tag, " issued"}, 64'(bus.oISSUED_CNT), 64'd0);
    endtask

    initial begin
        vecT vecs [8];
        int  sc, k;

        for (int i = 0; i < DEPTH; i++) ram[i] = {6'h2A, 10'(i), 16'($urandom)};

        iRST = 1'b1;
        bus.iSTART = 1'b0; bus.iABORT = 1'b0;
        bus.iPROG_BASE = '0; bus.iPROG_LEN = '0;
        repeat (3) @(posedge iACLK);
        #1;
        check_all_zero("reset");
        iRST = 1'b0;

        vecs[0] = '{"T1 basic",          10'h010, 11'd4, 0, 1'b0, 10, 4};
        vecs[1] = '{"T3 len0",           10'h0AA, 11'd0, 0, 1'b0,  4, 0};
        vecs[2] = '{"T4 wrap",           10'h3FE, 11'd4, 0, 1'b0, 10, 4};
        vecs[3] = '{"T2 alt ready",      10'h020, 11'd8, 1, 1'b0, -1, 8};
        vecs[4] = '{"len1",              10'h155, 11'd1, 0, 1'b0,  7, 1};
        vecs[5] = '{"start while run",   10'h300, 11'd6, 0, 1'b1, 12, 6};
        vecs[6] = '{"start while drain", 10'h001, 11'd0, 0, 1'b1,  4, 0};
        vecs[7] = '{"wrap len3",         10'h3FF, 11'd3, 0, 1'b0,  9, 3};

        for (int v = 0; v < 8; v++)
            do_run(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].mode,
                   vecs[v].midStart, vecs[v].expDoneOff, vecs[v].expIssued);

        // Abort beats start in IDLE.
        clear_obs();
        readyMode = 0;
        @(posedge iACLK); #1;
        bus.iSTART = 1'b1; bus.iABORT = 1'b1; bus.iPROG_BASE = 10'h123; bus.iPROG_LEN = 11'd5;
        @(posedge iACLK); #1;
        bus.iSTART = 1'b0; bus.iABORT = 1'b0;
        check("abort+start busy", 64'(bus.oBUSY), 64'd0);
        repeat (3) @(posedge iACLK);
        #1;
        check("abort+start reads", 64'(rdAddrQ.size()), 64'd0);

        // T5: abort after two transfers, then a fresh one-instruction program.
        clear_obs();
        readyMode = 3; stopAfter = 2;
        start_prog(10'h200, 11'd10, sc);
        k = 0;
        while (gotQ.size() < 2 && k < 100) begin
            @(posedge iACLK);
            k++;
        end
        #2 bus.iABORT = 1'b1;
        @(posedge iACLK);
        #2 bus.iABORT = 1'b0;
        check("T5 valid after abort", 64'(bus.oINSTR_VALID), 64'd0);
        check("T5 busy after abort", 64'(bus.oBUSY), 64'd0);
        check("T5 done after abort", 64'(bus.oDONE), 64'd0);
        repeat (10) @(posedge iACLK);
        #1;
        check("T5 no done", 64'(doneCycQ.size()), 64'd0);
        check("T5 xfer count", 64'(gotQ.size()), 64'd2);
        if (gotQ.size() >= 2) begin
            check("T5 instr[0]", 64'(gotQ[0]), 64'(ram[10'h200]));
            check("T5 instr[1]", 64'(gotQ[1]), 64'(ram[10'h201]));
        end
        check("T5 issued", 64'(bus.oISSUED_CNT), 64'd2);
        do_run("T5 restart", 10'h100, 11'd1, 0, 1'b0, 7, 1);

        // T6: asynchronous reset between edges mid-run.
        clear_obs();
        readyMode = 0;
        start_prog(10'h080, 11'd10, sc);
        repeat (4) @(posedge iACLK);
        #3 iRST = 1'b1;
        #1;
        check_all_zero("T6 async rst");
        repeat (2) @(posedge iACLK);
        #1 iRST = 1'b0;
        check("T6 idle after release", 64'(bus.oBUSY), 64'd0);
        do_run("T6 restart", 10'h040, 11'd3, 0, 1'b0, 9, 3);

        // Random programs under random backpressure.
        for (int r = 0; r < 12; r++) begin
            logic [9:0]  rb;
            logic [10:0] rl;
            rb = 10'($urandom_range(0, DEPTH - 1));
            rl = 11'($urandom_range(0, 20));
            do_run($sformatf("rand%0d", r), rb, rl, 2, (r % 3) == 0, -1, int'(rl));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
